// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) definitions for the decryption datapath.
// Contents: field reduction constant, InvMixColumns recurrence coefficients
// d0..d3 (row order of the serial accumulator), and the xtime helper.
package aes_pkg;

   localparam logic [7:0] AES_POLY_LOW = 8'h1B;  // x^8 = x^4+x^3+x+1

   // Coefficient multiplied into accumulator R_p on every byte.
   localparam logic [7:0] D0 = 8'h09;
   localparam logic [7:0] D1 = 8'h0D;
   localparam logic [7:0] D2 = 8'h0B;
   localparam logic [7:0] D3 = 8'h0E;

   typedef logic [7:0] gf_byte_t;

   // Multiply by x (8'h02) in GF(2^8).
   function automatic gf_byte_t xtime(input gf_byte_t v);
      return {v[6:0], 1'b0} ^ (v[7] ? AES_POLY_LOW : 8'h00);
   endfunction

endpackage

// File: rtl/inv_mix_columns_serial_if.sv
// Byte-stream bundle for the serial InvMixColumns engine.
//   in_byte    : state byte, one per clock (row 0 first)
//   enable     : feedback mask, 8'h00 starts a column, 8'hFF continues
//   out_byte_1..out_byte_4 : accumulated column rows 0..3
// master drives the byte stream and reads the column; slave is the engine.
interface inv_mix_columns_serial_if;
   import aes_pkg::*;

   gf_byte_t in_byte;
   gf_byte_t enable;
   gf_byte_t out_byte_1;
   gf_byte_t out_byte_2;
   gf_byte_t out_byte_3;
   gf_byte_t out_byte_4;

   modport master (
      output in_byte, enable,
      input  out_byte_1, out_byte_2, out_byte_3, out_byte_4
   );

   modport slave (
      input  in_byte, enable,
      output out_byte_1, out_byte_2, out_byte_3, out_byte_4
   );

endinterface

// File: rtl/inv_mix_columns_serial_gf_mul_inv_coeffs.sv
// Constant GF(2^8) multiplier producing the four InvMixColumns products of
// one byte from a single shared xtime chain (x2, x4, x8). Purely combinational.
//   a      : input byte
//   mul_09 : 09*a      mul_0d : 0D*a
//   mul_0b : 0B*a      mul_0e : 0E*a
module gf_mul_inv_coeffs
   import aes_pkg::*;
(
   input  gf_byte_t a,
   output gf_byte_t mul_09,
   output gf_byte_t mul_0d,
   output gf_byte_t mul_0b,
   output gf_byte_t mul_0e
);

   gf_byte_t x2;
   gf_byte_t x4;
   gf_byte_t x8;

   always_comb begin
      x2     = xtime(a);
      x4     = xtime(x2);
      x8     = xtime(x4);
      mul_09 = x8 ^ a;
      mul_0d = x8 ^ x4 ^ a;
      mul_0b = x8 ^ x2 ^ a;
      mul_0e = x8 ^ x4 ^ x2;
   end

endmodule

// File: rtl/inv_mix_columns_serial.sv
// Byte-serial AES InvMixColumns engine.
// Each clock: R_p <= (R_{(p+1) mod 4} & enable) ^ (d_p * in_byte),
// with d = {09, 0D, 0B, 0E}. After four bytes (enable 00,FF,FF,FF) the
// registers hold InvMixColumns of the column. No counter or valid flag:
// framing is done by the caller through enable.
// Ports:
//   clock      : rising-edge system clock
//   reset_n    : asynchronous active-low clear of R0..R3
//   in_byte    : state byte captured every edge
//   enable     : per-bit feedback mask
//   out_byte_1..out_byte_4 : registers R0..R3 (registered outputs)
module inv_mix_columns_serial
   import aes_pkg::*;
(
   input  logic     clock,
   input  logic     reset_n,
   input  gf_byte_t in_byte,
   input  gf_byte_t enable,
   output gf_byte_t out_byte_1,
   output gf_byte_t out_byte_2,
   output gf_byte_t out_byte_3,
   output gf_byte_t out_byte_4
);

   gf_byte_t prod_0;  // d0*a = 09*a
   gf_byte_t prod_1;  // d1*a = 0D*a
   gf_byte_t prod_2;  // d2*a = 0B*a
   gf_byte_t prod_3;  // d3*a = 0E*a

   gf_byte_t r0;
   gf_byte_t r1;
   gf_byte_t r2;
   gf_byte_t r3;

   gf_mul_inv_coeffs u_mul (
      .a      (in_byte),
      .mul_09 (prod_0),
      .mul_0d (prod_1),
      .mul_0b (prod_2),
      .mul_0e (prod_3)
   );

   // Rotating accumulators: each register takes its neighbour's masked value,
   // so after four bytes every row has seen every coefficient once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r0 <= '0;
         r1 <= '0;
         r2 <= '0;
         r3 <= '0;
      end else begin
         r0 <= (r1 & enable) ^ prod_0;
         r1 <= (r2 & enable) ^ prod_1;
         r2 <= (r3 & enable) ^ prod_2;
         r3 <= (r0 & enable) ^ prod_3;
      end
   end

   assign out_byte_1 = r0;
   assign out_byte_2 = r1;
   assign out_byte_3 = r2;
   assign out_byte_4 = r3;

endmodule

// File: tb/tb_inv_mix_columns_serial.sv
// Self-checking bench for inv_mix_columns_serial: expected columns are
// pushed to a scoreboard queue as stimulus is driven and popped when the
// column completes.
`timescale 1ns/1ps
module tb_inv_mix_columns_serial;

   logic clock = 1'b0;
   logic reset_n;

   always #10 clock = ~clock;

   inv_mix_columns_serial_if ifc ();

   inv_mix_columns_serial dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_byte    (ifc.in_byte),
      .enable     (ifc.enable),
      .out_byte_1 (ifc.out_byte_1),
      .out_byte_2 (ifc.out_byte_2),
      .out_byte_3 (ifc.out_byte_3),
      .out_byte_4 (ifc.out_byte_4)
   );

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   logic [31:0] exp_q[$];

   // Shift-and-add GF(2^8) multiply, independent of the xtime chain in the RTL.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [31:0] inv_mix(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] a2, input logic [7:0] a3);
      logic [7:0] r0, r1, r2, r3;
      r0 = gmul(8'h0E, a0) ^ gmul(8'h0B, a1) ^ gmul(8'h0D, a2) ^ gmul(8'h09, a3);
      r1 = gmul(8'h09, a0) ^ gmul(8'h0E, a1) ^ gmul(8'h0B, a2) ^ gmul(8'h0D, a3);
      r2 = gmul(8'h0D, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0E, a2) ^ gmul(8'h0B, a3);
      r3 = gmul(8'h0B, a0) ^ gmul(8'h0D, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0E, a3);
      return {r0, r1, r2, r3};
   endfunction

   function automatic logic [31:0] outs();
      return {ifc.out_byte_1, ifc.out_byte_2, ifc.out_byte_3, ifc.out_byte_4};
   endfunction

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_pop(input string tag);
      if (exp_q.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: scoreboard empty, got %08h", tag, outs());
      end else begin
         check_vec(tag, outs(), exp_q.pop_front());
      end
   endtask

   // Apply one byte; returns 1 ns after the capturing edge.
   task automatic drive(input logic [7:0] b, input logic [7:0] en);
      ifc.in_byte = b;
      ifc.enable  = en;
      @(posedge clock);
      #1;
   endtask

   task automatic send_col(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] a2, input logic [7:0] a3,
                           input logic [7:0] en0, input logic [31:0] exp);
      exp_q.push_back(exp);
      drive(a0, en0);
      drive(a1, 8'hFF);
      drive(a2, 8'hFF);
      drive(a3, 8'hFF);
      check_pop(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] b [4];
      logic [7:0] a;

      // Power-on reset with live inputs.
      reset_n     = 1'b0;
      ifc.in_byte = 8'hA5;
      ifc.enable  = 8'hFF;
      @(posedge clock);
      #1;
      check_vec("reset_hold", outs(), 32'h0);
      reset_n = 1'b1;

      // Directed columns.
      send_col("col_75ec", 8'h75, 8'hEC, 8'h09, 8'h93, 8'h00, 32'hACC1D6B8);
      send_col("col_8e4d", 8'h8E, 8'h4D, 8'hA1, 8'hBC, 8'h00, 32'hDB135345);

      // New column start right after: no carry-over from the previous result.
      a = 8'h5C;
      exp_q.push_back({gmul(8'h09, a), gmul(8'h0D, a), gmul(8'h0B, a), gmul(8'h0E, a)});
      drive(a, 8'h00);
      check_pop("new_col_a0");
      exp_q.push_back(inv_mix(a, 8'h11, 8'hF0, 8'h3E));
      drive(8'h11, 8'hFF);
      drive(8'hF0, 8'hFF);
      drive(8'h3E, 8'hFF);
      check_pop("new_col_full");

      send_col("impulse", 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0E090D0B);
      send_col("ones",    8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 32'h01010101);

      // Back-to-back pair against the software model.
      send_col("b2b_1", 8'h75, 8'hEC, 8'h09, 8'h93, 8'h00, inv_mix(8'h75, 8'hEC, 8'h09, 8'h93));
      send_col("b2b_2", 8'h20, 8'h0B, 8'h63, 8'h33, 8'h00, inv_mix(8'h20, 8'h0B, 8'h63, 8'h33));

      // Reset mid-column: async clear, held through an edge, then a column
      // fed entirely with enable=FF.
      drive(8'h3A, 8'h00);
      drive(8'hC7, 8'hFF);
      #4;
      reset_n = 1'b0;
      #1;
      check_vec("reset_async", outs(), 32'h0);
      @(posedge clock);
      #1;
      check_vec("reset_edge", outs(), 32'h0);
      reset_n = 1'b1;
      send_col("after_reset", 8'hD4, 8'hBF, 8'h5D, 8'h30, 8'hFF, inv_mix(8'hD4, 8'hBF, 8'h5D, 8'h30));

      // Random back-to-back columns.
      for (int n = 0; n < 1000; n++) begin
         for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
         send_col("random", b[0], b[1], b[2], b[3], 8'h00, inv_mix(b[0], b[1], b[2], b[3]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/inv_mix_columns_serial.md
# inv_mix_columns_serial

Byte-serial AES InvMixColumns engine for the decryption datapath. It accepts one state byte per clock, four bytes per column (row 0 first), and accumulates the GF(2^8) matrix product in four rotating registers. The finished 4-byte output column is available in parallel on the cycle after the fourth byte is captured. It sits between InvShiftRows/InvSubBytes byte streaming and the round-key/state register logic.

## Interface
- No parameters. The coefficients and the field polynomial are fixed.
- clock  in  1  single system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_byte  in  8  input state byte, captured every rising edge.
- enable  in  8  per-bit feedback mask. 8'h00 starts a new column; 8'hFF continues accumulation.
- out_byte_1  out  8  accumulator R0, column row 0.
- out_byte_2  out  8  accumulator R1, column row 1.
- out_byte_3  out  8  accumulator R2, column row 2.
- out_byte_4  out  8  accumulator R3, column row 3.

## Operation
- Constants: d0=8'h09, d1=8'h0D, d2=8'h0B, d3=8'h0E.
- Field: GF(2^8) with polynomial x^8+x^4+x^3+x+1. xtime(v) = {v[6:0],1'b0} ^ (v[7] ? 8'h1B : 8'h00).
- Per edge, with a = in_byte and p = 0..3: R_p <= (R_{(p+1) mod 4} & enable) ^ (d_p · a).
- The four products are formed combinationally from xtime chains (x2, x4, x8) and XORs. No lookup tables.
- After bytes a0..a3 are fed, with enable=00 on a0 and FF on a1..a3, R equals InvMixColumns(a0..a3):
  - R0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3
  - R1 = 09·a0 ^ 0E·a1 ^ 0B·a2 ^ 0D·a3
  - R2 = 0D·a0 ^ 09·a1 ^ 0E·a2 ^ 0B·a3
  - R3 = 0B·a0 ^ 0D·a1 ^ 09·a2 ^ 0E·a3
- No byte counter and no valid flag. Column framing is the caller's responsibility through enable.
- Other enable values apply the mask bitwise. The recurrence above is the defined behaviour.
- More than four bytes with enable=FF keeps applying the recurrence. No saturation, wrap detection or error.

## Timing
- Reset: R0..R3 = 8'h00 immediately and asynchronously. Outputs read 00 while reset_n is low.
- Outputs are the registers themselves, with no combinational path from the inputs.
- Latency: the result is valid after the rising edge that captures a3, and stays valid until the next edge.
- Throughput: one column per four clocks, back-to-back. A new column's a0 with enable=00 directly follows the previous a3.
- Partial outputs during a column reflect the partial recurrence and are not meaningful.
- Reset mid-column: registers clear. Because all accumulators are zero, four following bytes with enable=FF still produce a correct column.
- Simultaneous reset and edge: reset wins.

## Structure
- Shared package aes_pkg:
  - constant AES_POLY_LOW = 8'h1B
  - the d0..d3 coefficients
  - function xtime
- Natural sub-module: gf_mul_inv_coeffs. It maps one 8-bit input to four outputs (·09, ·0D, ·0B, ·0E) sharing one xtime chain.
- Top level: the sub-module, four 8-bit registers with async clear, and the mask/XOR feedback.

## Test plan
- Reset: assert reset_n=0 mid-stream, then release -> all outputs 00. Check all outputs read 00 while reset_n is low.
- Column 75,EC,09,93 (enable 00,FF,FF,FF), one byte per 20 ns clock -> after the 4th edge out_byte_1..4 = AC,C1,D6,B8.
- Column 8E,4D,A1,BC -> DB,13,53,45. Immediately follow with the next column's first byte under enable=00, and check no contamination.
- Impulse 01,00,00,00 -> 0E,09,0D,0B. Column 01,01,01,01 -> 01,01,01,01.
- Back-to-back columns 75,EC,09,93 then 20,0B,63,33 -> second result matches the software InvMixColumns model exactly.
- Random columns (≥1000) against a reference model. Include a reset pulse mid-column followed by four bytes with enable=FF -> result is correct.
